wr_burst_packer: RTL and testbench

- Downstream consumer of the dual sync_fifo write-data buffer stage in the LPDDR4 controller.
- Pops DLA_DATA_W-bit words from the selected FIFO output and assembles BURST_LEN-beat write bursts (BL16 by default).
- Presents each burst to the command/data scheduler over a valid/ready handshake, with an auto-incrementing burst address.
- A flush request emits a masked partial burst from a FIFO holding fewer than BURST_LEN words.

---
 rtl/wr_burst_packer_if.sv | 28 ++
 rtl/wr_burst_packer.sv | 126 ++++++++++++
 tb/tb_wr_burst_packer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_burst_packer_if.sv
// Burst packer bus: write-data FIFO read side plus the burst handshake toward the scheduler.
// master = packer side, slave = FIFO/scheduler side.
interface wr_burst_packer_if #(
    parameter int DLA_DATA_W  = 32,
    parameter int FIFO_ADDR_W = 4,
    parameter int BURST_LEN   = 16,
    parameter int ADDR_W      = 16
);
    logic                            fifo_empty_i;
    logic [FIFO_ADDR_W:0]            fifo_level_i;
    logic [DLA_DATA_W-1:0]           fifo_data_i;
    logic                            fifo_rd_o;
    logic                            burst_valid_o;
    logic                            burst_ready_i;
    logic [DLA_DATA_W*BURST_LEN-1:0] burst_data_o;
    logic [BURST_LEN-1:0]            burst_mask_o;
    logic [ADDR_W-1:0]               burst_addr_o;

    modport master (
        input  fifo_empty_i, fifo_level_i, fifo_data_i, burst_ready_i,
        output fifo_rd_o, burst_valid_o, burst_data_o, burst_mask_o, burst_addr_o
    );

    modport slave (
        output fifo_empty_i, fifo_level_i, fifo_data_i, burst_ready_i,
        input  fifo_rd_o, burst_valid_o, burst_data_o, burst_mask_o, burst_addr_o
    );
endinterface

// File: rtl/wr_burst_packer.sv
// Pops FIFO words into BURST_LEN-beat write bursts (masked partial bursts on flush)
// and hands them to the scheduler with an auto-incrementing burst address.
//
// state  | meaning
// IDLE   | waiting for a full burst (enable) or a partial flush
// POP    | one FIFO pop per cycle, capturing the previous pop's data
// CAP    | capture the final beat returned by the last pop
// HOLD   | burst presented, waiting for burst_ready_i
module wr_burst_packer #(
    parameter int DLA_DATA_W  = 32,
    parameter int FIFO_ADDR_W = 4,
    parameter int BURST_LEN   = 16,
    parameter int ADDR_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               underflow_o,
    wr_burst_packer_if.master  bus
);
    localparam int CNT_W = FIFO_ADDR_W + 1;
    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int BUS_W = DLA_DATA_W * BURST_LEN;

    typedef enum logic [1:0] {S_IDLE, S_POP, S_CAP, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     target_q, target_d;
    logic [CNT_W-1:0]     pop_cnt_q, pop_cnt_d;
    logic [BUS_W-1:0]     data_q, data_d;
    logic [BURST_LEN-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 underflow_q, underflow_d;
    logic                 capture;
    logic [IDX_W-1:0]     cap_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            pop_cnt_q   <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            addr_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            pop_cnt_q   <= pop_cnt_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        pop_cnt_d   = pop_cnt_q;
        data_d      = data_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        underflow_d = underflow_q;
        capture     = 1'b0;
        // Read data lags the pop by one cycle, so the beat written is the previous pop's.
        cap_idx     = IDX_W'(pop_cnt_q - 1'b1);

        case (state_q)
            S_IDLE: begin
                if (enable_i && (bus.fifo_level_i >= CNT_W'(BURST_LEN))) begin
                    target_d  = CNT_W'(BURST_LEN);
                    state_d   = S_POP;
                    data_d    = '0;
                    mask_d    = '0;
                    pop_cnt_d = '0;
                end else if (flush_i && (bus.fifo_level_i != '0)
                             && (bus.fifo_level_i < CNT_W'(BURST_LEN))) begin
                    target_d  = bus.fifo_level_i;
                    state_d   = S_POP;
                    data_d    = '0;
                    mask_d    = '0;
                    pop_cnt_d = '0;
                end
            end
            S_POP: begin
                capture   = (pop_cnt_q != '0);
                pop_cnt_d = pop_cnt_q + 1'b1;
                if (bus.fifo_empty_i) begin
                    underflow_d = 1'b1;
                end
                if (pop_cnt_q == target_q - 1'b1) begin
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                capture = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.burst_ready_i) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int k = 0; k < BURST_LEN; k++) begin
            if (capture && (cap_idx == IDX_W'(k))) begin
                data_d[k*DLA_DATA_W +: DLA_DATA_W] = bus.fifo_data_i;
                mask_d[k]                          = 1'b1;
            end
        end
    end

    assign bus.fifo_rd_o     = (state_q == S_POP);
    assign bus.burst_valid_o = (state_q == S_HOLD);
    assign bus.burst_data_o  = data_q;
    assign bus.burst_mask_o  = mask_q;
    assign bus.burst_addr_o  = addr_q;
    assign busy_o            = (state_q != S_IDLE);
    assign underflow_o       = underflow_q;
endmodule

// File: tb/tb_wr_burst_packer.sv
// Bench for wr_burst_packer: a queue-backed FIFO feeds the packer and every burst is
// compared against bursts derived from the words loaded and the packing rules.
module tb_wr_burst_packer;
    localparam int W  = 32;
    localparam int FA = 4;
    localparam int BL = 16;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst, enable, flush;
    logic busy, underflow;

    wr_burst_packer_if #(.DLA_DATA_W(W), .FIFO_ADDR_W(FA), .BURST_LEN(BL), .ADDR_W(AW)) bus();

    wr_burst_packer #(.DLA_DATA_W(W), .FIFO_ADDR_W(FA), .BURST_LEN(BL), .ADDR_W(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .flush_i     (flush),
        .busy_o      (busy),
        .underflow_o (underflow),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [W-1:0]  fifo_q[$];
    bit            force_empty = 1'b0;
    bit            pop_pend, rd_prev, valid_prev;
    int            cyc = 0, t_first = 0, t_valid = 0, pops = 0;
    logic [AW-1:0] exp_addr;

    // FIFO model: read data appears the cycle after the pop; level/empty follow completed pops.
    initial begin
        pop_pend = 1'b0; rd_prev = 1'b0; valid_prev = 1'b0;
        bus.fifo_data_i  = '0;
        bus.fifo_level_i = '0;
        bus.fifo_empty_i = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (pop_pend) begin
                if (fifo_q.size() > 0) bus.fifo_data_i = fifo_q.pop_front();
                else                   bus.fifo_data_i = $urandom;
            end
            pop_pend = bus.fifo_rd_o;
            if (bus.fifo_rd_o) pops++;
            if (bus.fifo_rd_o && !rd_prev) t_first = cyc;
            if (bus.burst_valid_o && !valid_prev) t_valid = cyc;
            rd_prev    = bus.fifo_rd_o;
            valid_prev = bus.burst_valid_o;
            bus.fifo_level_i = (fifo_q.size() > 31) ? 5'd31 : 5'(fifo_q.size());
            bus.fifo_empty_i = (fifo_q.size() == 0) || force_empty;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.burst_valid_o) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_addr = '0;
    endtask

    // Expected burst image: first n words from offset off, remaining beats zero.
    function automatic logic [W*BL-1:0] exp_beats(input logic [W-1:0] words[$], input int off, input int n);
        logic [W*BL-1:0] d;
        d = '0;
        for (int k = 0; k < n; k++) d[k*W +: W] = words[off+k];
        return d;
    endfunction

    function automatic logic [BL-1:0] exp_mask(input int n);
        return BL'((32'd1 << n) - 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; flush = 1'b0; bus.burst_ready_i = 1'b0;
        repeat (3) step();
        n_checks++; if (bus.burst_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.burst_valid_o); else n_pass++;
        n_checks++; if (bus.fifo_rd_o !== 1'b0) $display("FAIL rst_rd: got %b want 0", bus.fifo_rd_o); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.burst_data_o !== '0) $display("FAIL rst_data: got %h want 0", bus.burst_data_o); else n_pass++;
        n_checks++; if (bus.burst_mask_o !== '0) $display("FAIL rst_mask: got %h want 0", bus.burst_mask_o); else n_pass++;
        n_checks++; if (bus.burst_addr_o !== '0) $display("FAIL rst_addr: got %h want 0", bus.burst_addr_o); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL rst_underflow: got %b want 0", underflow); else n_pass++;
        rst = 1'b0;
        exp_addr = '0;
        step();
    endtask

    task automatic test_full_burst();
        logic [W-1:0] words[$];
        bit ok;
        for (int i = 0; i < 16; i++) words.push_back(W'(i));
        foreach (words[i]) fifo_q.push_back(words[i]);
        bus.burst_ready_i = 1'b1; pops = 0; enable = 1'b1;
        wait_valid(60, ok);
        n_checks++; if (!ok) $display("FAIL full_valid_timeout: valid never rose"); else n_pass++;
        n_checks++; if (t_valid - t_first !== 17) $display("FAIL full_latency: got %0d want 17", t_valid - t_first); else n_pass++;
        n_checks++; if (pops !== 16) $display("FAIL full_pops: got %0d want 16", pops); else n_pass++;
        n_checks++; if (bus.burst_data_o !== exp_beats(words, 0, 16)) $display("FAIL full_data: got %h want %h", bus.burst_data_o, exp_beats(words, 0, 16)); else n_pass++;
        n_checks++; if (bus.burst_mask_o !== 16'hFFFF) $display("FAIL full_mask: got %h want ffff", bus.burst_mask_o); else n_pass++;
        n_checks++; if (bus.burst_addr_o !== exp_addr) $display("FAIL full_addr: got %h want %h", bus.burst_addr_o, exp_addr); else n_pass++;
        step();
        exp_addr++;
        enable = 1'b0;
        n_checks++; if (bus.burst_valid_o !== 1'b0) $display("FAIL full_valid_drop: got %b want 0", bus.burst_valid_o); else n_pass++;
        n_checks++; if (bus.burst_addr_o !== exp_addr) $display("FAIL full_addr_inc: got %h want %h", bus.burst_addr_o, exp_addr); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] words[$];
        bit ok;
        for (int i = 0; i < 16; i++) words.push_back($urandom);
        foreach (words[i]) fifo_q.push_back(words[i]);
        bus.burst_ready_i = 1'b0; pops = 0; enable = 1'b1;
        wait_valid(60, ok);
        enable = 1'b0;
        n_checks++; if (!ok) $display("FAIL bp_valid_timeout: valid never rose"); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.burst_valid_o !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.burst_valid_o); else n_pass++;
            n_checks++; if (bus.burst_data_o !== exp_beats(words, 0, 16)) $display("FAIL bp_hold_data[%0d]: got %h want %h", i, bus.burst_data_o, exp_beats(words, 0, 16)); else n_pass++;
            n_checks++; if (bus.burst_mask_o !== 16'hFFFF) $display("FAIL bp_hold_mask[%0d]: got %h want ffff", i, bus.burst_mask_o); else n_pass++;
            n_checks++; if (bus.burst_addr_o !== exp_addr) $display("FAIL bp_hold_addr[%0d]: got %h want %h", i, bus.burst_addr_o, exp_addr); else n_pass++;
            step();
        end
        n_checks++; if (pops !== 16) $display("FAIL bp_no_extra_pops: got %0d want 16", pops); else n_pass++;
        bus.burst_ready_i = 1'b1;
        step();
        exp_addr++;
        n_checks++; if (bus.burst_valid_o !== 1'b0) $display("FAIL bp_accept: valid got %b want 0", bus.burst_valid_o); else n_pass++;
        n_checks++; if (bus.burst_addr_o !== exp_addr) $display("FAIL bp_addr_inc: got %h want %h", bus.burst_addr_o, exp_addr); else n_pass++;
    endtask

    task automatic test_flush_partial();
        logic [W-1:0] words[$];
        bit ok;
        for (int i = 0; i < 5; i++) words.push_back(W'(32'hA0 + i));
        foreach (words[i]) fifo_q.push_back(words[i]);
        bus.burst_ready_i = 1'b1; pops = 0; enable = 1'b0; flush = 1'b1;
        wait_valid(40, ok);
        n_checks++; if (!ok) $display("FAIL flush_valid_timeout: valid never rose"); else n_pass++;
        n_checks++; if (t_valid - t_first !== 6) $display("FAIL flush_latency: got %0d want 6", t_valid - t_first); else n_pass++;
        n_checks++; if (pops !== 5) $display("FAIL flush_pops: got %0d want 5", pops); else n_pass++;
        n_checks++; if (bus.burst_mask_o !== 16'h001F) $display("FAIL flush_mask: got %h want 001f", bus.burst_mask_o); else n_pass++;
        n_checks++; if (bus.burst_data_o !== exp_beats(words, 0, 5)) $display("FAIL flush_data: got %h want %h", bus.burst_data_o, exp_beats(words, 0, 5)); else n_pass++;
        n_checks++; if (bus.burst_addr_o !== exp_addr) $display("FAIL flush_addr: got %h want %h", bus.burst_addr_o, exp_addr); else n_pass++;
        step();
        exp_addr++;
        repeat (10) step();
        n_checks++; if (busy !== 1'b0 || pops !== 5) $display("FAIL flush_ignored_empty: busy %b pops %0d want 0/5", busy, pops); else n_pass++;
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[$];
        bit ok;
        int prev_first = 0;
        int n;
        do_reset();
        for (int i = 0; i < 20; i++) words.push_back($urandom);
        foreach (words[i]) fifo_q.push_back(words[i]);
        bus.burst_ready_i = 1'b1; pops = 0; enable = 1'b1; flush = 1'b1;
        for (int b = 0; b < 2; b++) begin
            n = (b == 0) ? 16 : 4;
            wait_valid(60, ok);
            n_checks++; if (!ok) $display("FAIL b2b_valid_timeout[%0d]: valid never rose", b); else n_pass++;
            n_checks++; if (t_valid - t_first !== n + 1) $display("FAIL b2b_latency[%0d]: got %0d want %0d", b, t_valid - t_first, n + 1); else n_pass++;
            n_checks++; if (bus.burst_mask_o !== exp_mask(n)) $display("FAIL b2b_mask[%0d]: got %h want %h", b, bus.burst_mask_o, exp_mask(n)); else n_pass++;
            n_checks++; if (bus.burst_data_o !== exp_beats(words, 16 * b, n)) $display("FAIL b2b_data[%0d]: got %h want %h", b, bus.burst_data_o, exp_beats(words, 16 * b, n)); else n_pass++;
            n_checks++; if (bus.burst_addr_o !== AW'(b)) $display("FAIL b2b_addr[%0d]: got %h want %0d", b, bus.burst_addr_o, b); else n_pass++;
            if (b == 1) begin
                n_checks++; if (t_first - prev_first !== 19) $display("FAIL b2b_spacing: got %0d want 19", t_first - prev_first); else n_pass++;
            end
            prev_first = t_first;
            step();
            exp_addr++;
        end
        n_checks++; if (pops !== 20) $display("FAIL b2b_pops: got %0d want 20", pops); else n_pass++;
        enable = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        bit reached = 1'b0;
        for (int i = 0; i < 16; i++) fifo_q.push_back($urandom);
        bus.burst_ready_i = 1'b0; pops = 0; enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (pops == 7) begin
                reached = 1'b1;
                break;
            end
            step();
        end
        n_checks++; if (!reached) $display("FAIL rmid_reach_beat7: pops got %0d want 7", pops); else n_pass++;
        rst = 1'b1;
        step();
        n_checks++; if (bus.fifo_rd_o !== 1'b0) $display("FAIL rmid_rd: got %b want 0", bus.fifo_rd_o); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.burst_data_o !== '0 || bus.burst_mask_o !== '0) $display("FAIL rmid_data_mask: got %h/%h want 0/0", bus.burst_data_o, bus.burst_mask_o); else n_pass++;
        n_checks++; if (bus.burst_addr_o !== '0) $display("FAIL rmid_addr: got %h want 0", bus.burst_addr_o); else n_pass++;
        rst = 1'b0; enable = 1'b0; exp_addr = '0;
        step();
        n_checks++; if (bus.fifo_rd_o !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_idle_after: rd %b busy %b want 0/0", bus.fifo_rd_o, busy); else n_pass++;
        fifo_q.delete();
        step();
    endtask

    task automatic test_addr_wrap();
        logic [W-1:0] words[$];
        bit ok;
        force dut.addr_q = 16'hFFFF;
        step();
        release dut.addr_q;
        exp_addr = 16'hFFFF;
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        foreach (words[i]) fifo_q.push_back(words[i]);
        bus.burst_ready_i = 1'b1; flush = 1'b1;
        wait_valid(40, ok);
        n_checks++; if (!ok || bus.burst_addr_o !== 16'hFFFF) $display("FAIL wrap_addr_pre: ok %b got %h want ffff", ok, bus.burst_addr_o); else n_pass++;
        step();
        flush = 1'b0;
        exp_addr++;
        n_checks++; if (bus.burst_addr_o !== 16'h0000 || exp_addr !== 16'h0000) $display("FAIL wrap_addr_post: got %h want 0000", bus.burst_addr_o); else n_pass++;
    endtask

    task automatic test_underflow();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
        bus.burst_ready_i = 1'b1; force_empty = 1'b1; flush = 1'b1;
        wait_valid(40, ok);
        n_checks++; if (!ok) $display("FAIL uf_valid_timeout: valid never rose"); else n_pass++;
        n_checks++; if (underflow !== 1'b1) $display("FAIL uf_set: got %b want 1", underflow); else n_pass++;
        step();
        flush = 1'b0; force_empty = 1'b0;
        repeat (5) step();
        n_checks++; if (underflow !== 1'b1) $display("FAIL uf_sticky: got %b want 1", underflow); else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_addr = '0;
        step();
        n_checks++; if (underflow !== 1'b0) $display("FAIL uf_cleared: got %b want 0", underflow); else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        int len, off, rem, n, hold;
        bit en;
        for (int it = 0; it < 10; it++) begin
            logic [W-1:0] words[$];
            len = $urandom_range(1, 31);
            en  = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) words.push_back($urandom);
            foreach (words[i]) fifo_q.push_back(words[i]);
            bus.burst_ready_i = 1'b0; pops = 0; flush = 1'b1; enable = en;
            if (!en && len >= BL) begin
                repeat (20) step();
                n_checks++; if (pops !== 0 || busy !== 1'b0) $display("FAIL rand_enable_gate[%0d]: pops %0d busy %b want 0/0", it, pops, busy); else n_pass++;
                enable = 1'b1;
                en = 1'b1;
            end
            off = 0;
            while (off < len) begin
                rem = len - off;
                n = (en && rem >= BL) ? BL : rem;
                wait_valid(80, ok);
                n_checks++; if (!ok) $display("FAIL rand_valid_timeout[%0d]: valid never rose", it); else n_pass++;
                n_checks++; if (t_valid - t_first !== n + 1) $display("FAIL rand_latency[%0d]: got %0d want %0d", it, t_valid - t_first, n + 1); else n_pass++;
                n_checks++; if (bus.burst_data_o !== exp_beats(words, off, n)) $display("FAIL rand_data[%0d]: got %h want %h", it, bus.burst_data_o, exp_beats(words, off, n)); else n_pass++;
                n_checks++; if (bus.burst_mask_o !== exp_mask(n)) $display("FAIL rand_mask[%0d]: got %h want %h", it, bus.burst_mask_o, exp_mask(n)); else n_pass++;
                n_checks++; if (bus.burst_addr_o !== exp_addr) $display("FAIL rand_addr[%0d]: got %h want %h", it, bus.burst_addr_o, exp_addr); else n_pass++;
                hold = $urandom_range(0, 3);
                repeat (hold) step();
                n_checks++; if (bus.burst_valid_o !== 1'b1) $display("FAIL rand_hold_valid[%0d]: got %b want 1", it, bus.burst_valid_o); else n_pass++;
                bus.burst_ready_i = 1'b1;
                step();
                bus.burst_ready_i = 1'b0;
                exp_addr++;
                n_checks++; if (bus.burst_valid_o !== 1'b0) $display("FAIL rand_valid_drop[%0d]: got %b want 0", it, bus.burst_valid_o); else n_pass++;
                off += n;
            end
            n_checks++; if (pops !== len) $display("FAIL rand_pops[%0d]: got %0d want %0d", it, pops, len); else n_pass++;
            enable = 1'b0; flush = 1'b0;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0;
        bus.burst_ready_i = 1'b0;
        exp_addr = '0;
        test_reset();
        test_full_burst();
        test_backpressure();
        test_flush_partial();
        test_back_to_back();
        test_reset_mid_burst();
        test_addr_wrap();
        test_underflow();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
